// File: rtl/frogger_lives_ctrl.sv
// Frogger game-state sequencer: turns lane collision and goal flags into lives,
// score, death/respawn timing and game-over, with every output registered.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | after reset, frog frozen, waiting for start
// S_PLAY  | frog moving, collisions and goal accepted
// S_DYING | frog frozen for DEATH_TICKS frame ticks after a hit
// S_GRACE | frog moving but immune for GRACE_TICKS ticks after respawn
// S_OVER  | no lives left, frozen, waiting for start
module frogger_lives_ctrl #(
  parameter int LIVES_INIT  = 3,
  parameter int LIFE_W      = 2,
  parameter int DEATH_TICKS = 8,
  parameter int GRACE_TICKS = 4
) (
  input  logic              SC_LIVES_CLOCK_50,
  input  logic              SC_LIVES_RESET_InLow,
  input  logic [7:0]        SC_LIVES_collision_InBus,
  input  logic              SC_LIVES_goal_In,
  input  logic              SC_LIVES_tick_In,
  input  logic              SC_LIVES_start_In,
  output logic [LIFE_W-1:0] SC_LIVES_lives_OutBus,
  output logic [7:0]        SC_LIVES_score_OutBus,
  output logic [2:0]        SC_LIVES_lane_OutBus,
  output logic              SC_LIVES_hit_Out,
  output logic              SC_LIVES_respawn_Out,
  output logic              SC_LIVES_freeze_Out,
  output logic              SC_LIVES_gameover_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_DYING,
    S_GRACE,
    S_OVER
  } state_t;

  localparam logic [LIFE_W-1:0] LIVES_LOAD = LIFE_W'(LIVES_INIT);
  localparam logic [LIFE_W-1:0] LIFE_ONE   = LIFE_W'(1);
  localparam logic [3:0]        DEATH_LOAD = 4'(DEATH_TICKS);
  localparam logic [3:0]        GRACE_LOAD = 4'(GRACE_TICKS);

  state_t     state;
  logic [3:0] tick_cnt;
  logic       any_hit;

  assign any_hit = |SC_LIVES_collision_InBus;

  // Scan from the top so the lowest set index is the one that sticks.
  function automatic logic [2:0] lowest_lane(input logic [7:0] flags);
    logic [2:0] lane;
    lane = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (flags[i]) lane = 3'(i);
    end
    return lane;
  endfunction

  always_ff @(posedge SC_LIVES_CLOCK_50 or negedge SC_LIVES_RESET_InLow) begin
    if (!SC_LIVES_RESET_InLow) begin
      state                 <= S_IDLE;
      tick_cnt              <= 4'd0;
      SC_LIVES_lives_OutBus <= LIVES_LOAD;
      SC_LIVES_score_OutBus <= 8'd0;
      SC_LIVES_lane_OutBus  <= 3'd0;
      SC_LIVES_hit_Out      <= 1'b0;
      SC_LIVES_respawn_Out  <= 1'b0;
      SC_LIVES_freeze_Out   <= 1'b1;
      SC_LIVES_gameover_Out <= 1'b0;
    end else begin
      SC_LIVES_hit_Out     <= 1'b0;
      SC_LIVES_respawn_Out <= 1'b0;
      case (state)
        S_IDLE, S_OVER: begin
          if (SC_LIVES_start_In) begin
            state                 <= S_PLAY;
            SC_LIVES_lives_OutBus <= LIVES_LOAD;
            SC_LIVES_score_OutBus <= 8'd0;
            SC_LIVES_lane_OutBus  <= 3'd0;
            SC_LIVES_respawn_Out  <= 1'b1;
            SC_LIVES_freeze_Out   <= 1'b0;
            SC_LIVES_gameover_Out <= 1'b0;
          end
        end
        S_PLAY: begin
          if (any_hit) begin
            SC_LIVES_hit_Out      <= 1'b1;
            SC_LIVES_lane_OutBus  <= lowest_lane(SC_LIVES_collision_InBus);
            SC_LIVES_lives_OutBus <= SC_LIVES_lives_OutBus - LIFE_ONE;
            SC_LIVES_freeze_Out   <= 1'b1;
            if (SC_LIVES_lives_OutBus == LIFE_ONE) begin
              state                 <= S_OVER;
              SC_LIVES_gameover_Out <= 1'b1;
            end else begin
              state    <= S_DYING;
              tick_cnt <= DEATH_LOAD;
            end
          end else if (SC_LIVES_goal_In) begin
            if (SC_LIVES_score_OutBus != 8'hFF)
              SC_LIVES_score_OutBus <= SC_LIVES_score_OutBus + 8'd1;
            SC_LIVES_respawn_Out <= 1'b1;
            state                <= S_GRACE;
            tick_cnt             <= GRACE_LOAD;
          end
        end
        S_DYING: begin
          if (SC_LIVES_tick_In) begin
            if (tick_cnt == 4'd1) begin
              state                <= S_GRACE;
              tick_cnt             <= GRACE_LOAD;
              SC_LIVES_respawn_Out <= 1'b1;
              SC_LIVES_freeze_Out  <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        S_GRACE: begin
          if (SC_LIVES_tick_In) begin
            if (tick_cnt == 4'd1) begin
              state    <= S_PLAY;
              tick_cnt <= 4'd0;
            end else begin
              tick_cnt <= tick_cnt - 4'd1;
            end
          end
        end
        default: begin
          state               <= S_IDLE;
          SC_LIVES_freeze_Out <= 1'b1;
        end
      endcase
    end
  end

endmodule
